// File: rtl/mc_merge_buffer.sv
// Multi-channel merge buffer: round-robin arbitration of NUM_CH valid/ready inputs
// into a DEPTH-entry first-word-fall-through FIFO, with source-channel tagging.
module mc_merge_buffer #(
    parameter  int unsigned N      = 32,
    parameter  int unsigned NUM_CH = 2,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH*N-1:0] in,
    input  logic [NUM_CH-1:0]   in_en,
    output logic [NUM_CH-1:0]   in_ready,
    output logic [N-1:0]        out,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_valid,
    input  logic                out_en,
    output logic [CNT_W-1:0]    count
);

    localparam int unsigned      AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    logic [N-1:0]     r_mem_data [DEPTH];
    logic [CH_W-1:0]  r_mem_ch   [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CH_W-1:0]  r_rr;

    logic             w_found;
    logic [CH_W-1:0]  w_grant;
    logic [N-1:0]     w_grant_data;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // First asserted in_en at or after r_rr, wrapping past the last channel.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        w_found      = 1'b0;
        w_grant      = '0;
        w_grant_data = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(r_rr) + k) % NUM_CH;
            if (!w_found && in_en[idx]) begin
                w_found      = 1'b1;
                w_grant      = CH_W'(idx);
                w_grant_data = in[idx*N +: N];
            end
        end
    end

    assign w_full    = (r_count == FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = w_found && !w_full && !rst;
    assign w_pop     = out_en && out_valid && !rst;
    assign count     = r_count;

    always_comb begin
        in_ready = '0;
        if (w_push) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_rr     <= (w_grant == LAST_CH) ? '0 : w_grant + CH_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_grant_data;
            r_mem_ch[r_wr_ptr]   <= w_grant;
        end
    end

    assign out    = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_ch = out_valid ? r_mem_ch[r_rd_ptr]   : '0;

endmodule

// File: tb/tb_mc_merge_buffer.sv
// Bench for mc_merge_buffer (N=32, NUM_CH=2, DEPTH=4): directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_mc_merge_buffer;

    localparam int N      = 32;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in = '0;
    logic [1:0]  in_en = '0;
    logic [1:0]  in_ready;
    logic [31:0] out;
    logic [0:0]  out_ch;
    logic        out_valid;
    logic        out_en = 1'b0;
    logic [2:0]  count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue of {channel, data}, plus round-robin start index.
    logic [32:0] mq[$];
    int          m_rr = 0;

    always #5 clk = ~clk;

    mc_merge_buffer #(.N(N), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in(in), .in_en(in_en), .in_ready(in_ready),
        .out(out), .out_ch(out_ch), .out_valid(out_valid), .out_en(out_en),
        .count(count)
    );

    function automatic int m_grant();
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (m_rr + k) % NUM_CH;
            if (in_en[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [1:0] m_ready();
        int g;
        g = m_grant();
        if (!rst && g >= 0 && mq.size() < DEPTH) return 2'(1 << g);
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_out();
        return (mq.size() > 0) ? mq[0][31:0] : 32'h0;
    endfunction

    function automatic logic m_ch();
        return (mq.size() > 0) ? mq[0][32] : 1'b0;
    endfunction

    task automatic drive(input logic r, input logic [1:0] en, input logic [31:0] d0,
                         input logic [31:0] d1, input logic oe);
        @(negedge clk);
        rst = r; in_en = en; in = {d1, d0}; out_en = oe;
        #1;
    endtask

    task automatic tick();
        int          g;
        bit          do_pop;
        bit          do_push;
        logic [32:0] w;
        g = m_grant();
        w = '0;
        if (rst) begin
            mq.delete();
            m_rr = 0;
        end else begin
            do_pop  = out_en && mq.size() > 0;
            do_push = g >= 0 && mq.size() < DEPTH;
            if (do_push) w = {g[0], in[g*32 +: 32]};
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(w);
                m_rr = (g + 1) % NUM_CH;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b11, 32'h1, 32'h2, 1'b0);
            n_total++; if (in_ready !== 2'b00) $display("FAIL reset_ready got %b exp 00", in_ready); else n_pass++;
            n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
            n_total++; if (out !== 32'h0) $display("FAIL reset_out got %0h exp 0", out); else n_pass++;
            n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
            tick();
        end
        drive(1'b0, 2'b11, 32'h1, 32'h2, 1'b0);
        n_total++; if (in_ready !== 2'b01) $display("FAIL release_ready got %b exp 01", in_ready); else n_pass++;
        tick();
    endtask

    task automatic test_single_push();
        do_reset();
        drive(1'b0, 2'b01, 32'h1, 32'h0, 1'b0);
        n_total++; if (in_ready !== 2'b01) $display("FAIL single_ready got %b exp 01", in_ready); else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out !== 32'h1) $display("FAIL single_out got %0h exp 1", out); else n_pass++;
        n_total++; if (out_ch !== 1'b0) $display("FAIL single_ch got %0d exp 0", out_ch); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_pop_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out !== 32'h0) $display("FAIL single_pop_out got %0h exp 0", out); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL single_pop_count got %0d exp 0", count); else n_pass++;
        tick();
    endtask

    task automatic test_arbitration();
        do_reset();
        drive(1'b0, 2'b11, 32'h1, 32'h2, 1'b0);
        n_total++; if (in_ready !== 2'b01) $display("FAIL arb_ready0 got %b exp 01", in_ready); else n_pass++;
        tick();
        drive(1'b0, 2'b11, 32'h1, 32'h2, 1'b0);
        n_total++; if (in_ready !== 2'b10) $display("FAIL arb_ready1 got %b exp 10", in_ready); else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        n_total++; if (count !== 3'd2) $display("FAIL arb_count got %0d exp 2", count); else n_pass++;
        n_total++; if ({out_ch, out} !== {1'b0, 32'h1}) $display("FAIL arb_pop0 got %0d/%0h exp 0/1", out_ch, out); else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        n_total++; if ({out_ch, out} !== {1'b1, 32'h2}) $display("FAIL arb_pop1 got %0d/%0h exp 1/2", out_ch, out); else n_pass++;
        tick();
        // Both channels held valid: grants alternate starting at ch0.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b11, 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b1);
            n_total++; if (in_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL arb_fair[%0d] got %b", i, in_ready); else n_pass++;
            n_total++; if (out !== m_out() || out_ch !== m_ch()) $display("FAIL arb_fair_out[%0d] got %0h/%0d exp %0h/%0d", i, out, out_ch, m_out(), m_ch()); else n_pass++;
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b01, 32'(5 + i), 32'h0, 1'b0);
            tick();
        end
        drive(1'b0, 2'b01, 32'h99, 32'h0, 1'b0);
        n_total++; if (count !== 3'd4) $display("FAIL full_count got %0d exp 4", count); else n_pass++;
        n_total++; if (in_ready !== 2'b00) $display("FAIL full_ready got %b exp 00", in_ready); else n_pass++;
        tick();
        drive(1'b0, 2'b01, 32'h99, 32'h0, 1'b1);
        n_total++; if (out !== 32'h5) $display("FAIL full_pop_out got %0h exp 5", out); else n_pass++;
        n_total++; if (in_ready !== 2'b00) $display("FAIL full_pop_ready got %b exp 00", in_ready); else n_pass++;
        tick();
        drive(1'b0, 2'b01, 32'h9, 32'h0, 1'b0);
        n_total++; if (count !== 3'd3) $display("FAIL full_after_count got %0d exp 3", count); else n_pass++;
        n_total++; if (in_ready !== 2'b01) $display("FAIL full_resume_ready got %b exp 01", in_ready); else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        n_total++; if (count !== 3'd4) $display("FAIL full_refill_count got %0d exp 4", count); else n_pass++;
        n_total++; if (out !== 32'h6) $display("FAIL full_head got %0h exp 6", out); else n_pass++;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(1'b0, 2'b01, 32'd10, 32'h0, 1'b0); tick();
        drive(1'b0, 2'b01, 32'd11, 32'h0, 1'b0); tick();
        drive(1'b0, 2'b01, 32'd9, 32'h0, 1'b1);
        n_total++; if (count !== 3'd2) $display("FAIL simul_count_pre got %0d exp 2", count); else n_pass++;
        n_total++; if (out !== 32'd10) $display("FAIL simul_pop got %0d exp 10", out); else n_pass++;
        n_total++; if (in_ready !== 2'b01) $display("FAIL simul_ready got %b exp 01", in_ready); else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        n_total++; if (count !== 3'd2) $display("FAIL simul_count_post got %0d exp 2", count); else n_pass++;
        n_total++; if (out !== 32'd11) $display("FAIL simul_head got %0d exp 11", out); else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        n_total++; if (out !== 32'd9) $display("FAIL simul_tail got %0d exp 9", out); else n_pass++;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b10, 32'h0, 32'h30 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 2'b10, 32'h0, 32'h77, 1'b1);
        n_total++; if (count !== 3'd3) $display("FAIL midrst_count_pre got %0d exp 3", count); else n_pass++;
        n_total++; if (in_ready !== 2'b00) $display("FAIL midrst_ready got %b exp 00", in_ready); else n_pass++;
        tick();
        drive(1'b0, 2'b01, 32'hA5, 32'h0, 1'b0);
        n_total++; if (count !== 3'd0) $display("FAIL midrst_count got %0d exp 0", count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out !== 32'h0) $display("FAIL midrst_out got %0h exp 0", out); else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        n_total++; if (out_valid !== 1'b1 || out !== 32'hA5) $display("FAIL midrst_first got %b/%0h exp 1/a5", out_valid, out); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic       oe;
            logic [1:0] en;
            r  = ($urandom_range(0, 49) == 0);
            en = 2'($urandom_range(0, 3));
            oe = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            drive(r, en, $urandom, $urandom, oe);
            n_total++; if (in_ready !== m_ready()) $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, m_ready()); else n_pass++;
            n_total++; if (count !== 3'(mq.size())) $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, mq.size()); else n_pass++;
            n_total++; if (out_valid !== (mq.size() != 0)) $display("FAIL rnd_valid[%0d] got %b", i, out_valid); else n_pass++;
            n_total++; if (out !== m_out()) $display("FAIL rnd_out[%0d] got %0h exp %0h", i, out, m_out()); else n_pass++;
            n_total++; if (out_ch !== m_ch()) $display("FAIL rnd_ch[%0d] got %0d exp %0d", i, out_ch, m_ch()); else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_arbitration();
        test_full();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_merge_buffer.md
Name: mc_merge_buffer

Overview:
- Parametrised successor to the two-input buffer: merges NUM_CH input channels of N-bit words into one output stream.
- Per-channel valid/ready handshake feeds a round-robin arbiter, which pushes at most one word per cycle into a DEPTH-entry first-word-fall-through FIFO.
- Output is consumed with out_en and tagged with the source channel index.
- Sits between multiple producers and a single downstream consumer.

Parameters:
- N, 32, data word width in bits (>=1).
- NUM_CH, 2, number of input channels (>=1).
- DEPTH, 4, FIFO entries; power of two, >=2.
- Derived (localparam): CH_W = max(1, clog2(NUM_CH)); CNT_W = clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- in  in  NUM_CH*N  channel data; channel i occupies bits [i*N +: N].
- in_en  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; combinational, one-hot or zero.
- out  out  N  FIFO head word; 0 when empty.
- out_ch  out  CH_W  source channel of head word; 0 when empty.
- out_valid  out  1  FIFO non-empty.
- out_en  in  1  pop request; ignored when out_valid=0.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at posedge) forces the following; the rst=1 cycle itself performs no push or pop:
  - count=0, out_valid=0, out=0, out_ch=0.
  - RR pointer=0; read and write pointers=0.
  - FIFO contents are discarded.
- Arbiter:
  - Searches in_en starting at index rr_ptr, ascending with wrap.
  - The first asserted channel g is granted.
  - in_ready[g]=1 only if count<DEPTH and rst=0; all other in_ready bits are 0.
  - Full FIFO: in_ready is all-zero. Ready does not depend on same-cycle out_en.
- Transfer: push when in_en[g] && in_ready[g]. It stores {g, in[g]} at the write pointer.
- RR pointer: after a push, rr_ptr <= (g+1) mod NUM_CH. With no push, rr_ptr holds.
- Pop: when out_en && out_valid, advance the read pointer.
- Latency: a word pushed at edge k into an empty FIFO appears on out/out_ch with out_valid=1 during the cycle after edge k. There is no bypass into the same cycle.
- Ordering: strict FIFO across channels; per-channel order is preserved.
- Pointers: log2(DEPTH) bits and wrap naturally. count tracks occupancy explicitly.
- Simultaneous push and pop: count is unchanged. This is legal at any 1<=count<=DEPTH-1.
- At count=DEPTH with a pop: no push occurs that cycle; in_ready returns the next cycle.
- Pop when empty: ignored, with no pointer or count change.
- Output gating: out and out_ch are driven 0 whenever out_valid=0, with no stale data.
- Channel with in_en high but not granted: it must hold its data. The block does not latch ungranted inputs.
- Reset mid-operation: the next cycle shows empty state regardless of prior occupancy or pending handshakes.
- NUM_CH=1: the arbiter degenerates to a pass-through and out_ch is constant 0.

Test Plan:
- Test configuration: N=32, NUM_CH=2, DEPTH=4.
- Reset: hold rst=1 for 5 cycles with in_en=2'b11 -> in_ready=0, out_valid=0, out=0, count=0 throughout; first cycle after release gives in_ready=2'b01.
- Single push: ch0 in=1, in_en=2'b01 for one cycle -> next cycle out_valid=1, out=1, out_ch=0, count=1. Then out_en=1 for one cycle -> out_valid=0, out=0, count=0.
- Arbitration: ch0=1, ch1=2, in_en=2'b11 held 2 cycles, then 0 -> pushes in order ch0, ch1. Pops yield (1,0) then (2,1). With ch0 continuously valid, ch1 is granted every other cycle.
- Full: out_en=0, push words 5,6,7,8 -> count=4, in_ready=0 with in_en high. One pop -> out=5 consumed, count=3; next cycle in_ready is non-zero and a push resumes.
- Simultaneous: at count=2, push 9 and pop together -> count stays 2; the popped word is the oldest entry and 9 lands at the tail.
- Mid-op reset: count=3, assert rst for 1 cycle -> next cycle count=0, out_valid=0, out=0. The next push of 0xA5 emerges first.
